// File: rtl/execute_mul_pipe.sv
// ----------------------------------------------------------------------------
// execute_mul_pipe
//
// Pipelined RV32M multiply execute unit. Accepts one micro-op per cycle from
// the issue mul FIFO, produces mul/mulh/mulhsu/mulhu results STAGES cycles
// later on the writeback port and drives the physical-register wakeup channel
// on every successful writeback.
//
// Ports:
//   clk                  clock, all state on the rising edge
//   rst                  asynchronous, active-low reset
//   issue_valid          issue FIFO head valid
//   issue_op             0=mul 1=mulh 2=mulhsu 3=mulhu
//   issue_src1/src2      operand values
//   issue_rob_id         ROB entry of the op
//   issue_rd_phy         destination physical register
//   issue_rd_enable      op writes rd
//   issue_has_exception  op carries an upstream exception
//   issue_pop            head accepted this cycle
//   wb_valid/wb_ready    writeback handshake
//   wb_value             result (0 for excepting ops)
//   wb_rob_id            ROB entry of the result
//   wb_rd_phy            destination register of the result
//   wb_rd_enable         result writes rd
//   wb_has_exception     exception passthrough
//   fb_enable            wakeup valid
//   fb_phy_id            wakeup register index
//   fb_value             wakeup value
//   flush                kills everything in flight
// ----------------------------------------------------------------------------
module execute_mul_pipe #(
    parameter int XLEN     = 32,
    parameter int STAGES   = 3,
    parameter int ROB_ID_W = 7,
    parameter int PHY_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [1:0]          issue_op,
    input  logic [XLEN-1:0]     issue_src1,
    input  logic [XLEN-1:0]     issue_src2,
    input  logic [ROB_ID_W-1:0] issue_rob_id,
    input  logic [PHY_W-1:0]    issue_rd_phy,
    input  logic                issue_rd_enable,
    input  logic                issue_has_exception,
    output logic                issue_pop,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [XLEN-1:0]     wb_value,
    output logic [ROB_ID_W-1:0] wb_rob_id,
    output logic [PHY_W-1:0]    wb_rd_phy,
    output logic                wb_rd_enable,
    output logic                wb_has_exception,
    output logic                fb_enable,
    output logic [PHY_W-1:0]    fb_phy_id,
    output logic [XLEN-1:0]     fb_value,
    input  logic                flush
);

    typedef struct packed {
        logic [XLEN-1:0]     value;
        logic [ROB_ID_W-1:0] rob_id;
        logic [PHY_W-1:0]    rd_phy;
        logic                rd_enable;
        logic                has_exception;
    } slot_t;

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] valid_next;
    slot_t             slot_reg  [STAGES];
    slot_t             slot_next [STAGES];
    logic [STAGES-1:0] adv;

    // ------------------------------------------------------------------
    // Arithmetic. Operands are extended straight to 2*XLEN bits (sign or
    // zero as the variant requires); the low 2*XLEN bits of that product
    // are identical to the low bits of the (XLEN+1)x(XLEN+1) signed
    // product, which is all the four variants ever select.
    // ------------------------------------------------------------------
    logic              src1_signed;
    logic              src2_signed;
    logic [2*XLEN-1:0] op_a_ext;
    logic [2*XLEN-1:0] op_b_ext;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   result;
    slot_t             in_slot;

    assign src1_signed = (issue_op == 2'd1) || (issue_op == 2'd2);
    assign src2_signed = (issue_op == 2'd1);
    assign op_a_ext    = {{XLEN{src1_signed & issue_src1[XLEN-1]}}, issue_src1};
    assign op_b_ext    = {{XLEN{src2_signed & issue_src2[XLEN-1]}}, issue_src2};
    assign product     = op_a_ext * op_b_ext;

    always_comb begin
        result = '0;
        if (!issue_has_exception) begin
            if (issue_op == 2'd0) begin
                result = product[XLEN-1:0];
            end else begin
                result = product[2*XLEN-1:XLEN];
            end
        end
    end

    always_comb begin
        in_slot               = '0;
        in_slot.value         = result;
        in_slot.rob_id        = issue_rob_id;
        in_slot.rd_phy        = issue_rd_phy;
        in_slot.rd_enable     = issue_rd_enable;
        in_slot.has_exception = issue_has_exception;
    end

    // ------------------------------------------------------------------
    // Advance logic. A stage may move when any stage from itself to the
    // output is empty, or the output is draining; this is the unrolled
    // form of adv[i] = !v[i] | adv[i+1] and collapses bubbles while the
    // output is stalled.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            assign adv[gi] = wb_ready | ~(&valid_reg[LAST:gi]);

            if (gi == 0) begin : g_head
                assign valid_next[gi] = flush ? 1'b0
                                      : (adv[gi] ? issue_pop : valid_reg[gi]);
                assign slot_next[gi]  = adv[gi] ? in_slot : slot_reg[gi];
            end else begin : g_body
                assign valid_next[gi] = flush ? 1'b0
                                      : (adv[gi] ? valid_reg[gi-1] : valid_reg[gi]);
                assign slot_next[gi]  = adv[gi] ? slot_reg[gi-1] : slot_reg[gi];
            end
        end
    endgenerate

    // Reset is folded in so the pop strobe drops the moment rst falls,
    // not only after the valid bits have been cleared.
    assign issue_pop = issue_valid & adv[0] & ~flush & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            for (int i = 0; i < STAGES; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            for (int i = 0; i < STAGES; i++) begin
                slot_reg[i] <= slot_next[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Writeback and wakeup, driven from the last slot.
    // ------------------------------------------------------------------
    assign wb_valid         = valid_reg[LAST] & ~flush;
    assign wb_value         = slot_reg[LAST].value;
    assign wb_rob_id        = slot_reg[LAST].rob_id;
    assign wb_rd_phy        = slot_reg[LAST].rd_phy;
    assign wb_rd_enable     = slot_reg[LAST].rd_enable;
    assign wb_has_exception = slot_reg[LAST].has_exception;

    assign fb_enable = wb_valid & wb_ready & slot_reg[LAST].rd_enable
                     & ~slot_reg[LAST].has_exception;
    assign fb_phy_id = slot_reg[LAST].rd_phy;
    assign fb_value  = slot_reg[LAST].value;

endmodule

// File: tb/tb_execute_mul_pipe.sv
module tb_execute_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [1:0]  issue_op;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic [6:0]  issue_rob_id;
    logic [5:0]  issue_rd_phy;
    logic        issue_rd_enable;
    logic        issue_has_exception;
    logic        wb_ready;
    logic        flush;

    // Index 0: STAGES=1, index 1: STAGES=3 (main, model-checked), index 2: STAGES=4
    logic        o_pop    [3];
    logic        o_valid  [3];
    logic [31:0] o_value  [3];
    logic [6:0]  o_rob    [3];
    logic [5:0]  o_rd     [3];
    logic        o_en     [3];
    logic        o_exc    [3];
    logic        o_fb     [3];
    logic [5:0]  o_fbphy  [3];
    logic [31:0] o_fbval  [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            execute_mul_pipe #(
                .XLEN(32),
                .STAGES(gi == 0 ? 1 : (gi == 1 ? 3 : 4)),
                .ROB_ID_W(7),
                .PHY_W(6)
            ) dut (
                .clk(clk),
                .rst(rst),
                .issue_valid(issue_valid),
                .issue_op(issue_op),
                .issue_src1(issue_src1),
                .issue_src2(issue_src2),
                .issue_rob_id(issue_rob_id),
                .issue_rd_phy(issue_rd_phy),
                .issue_rd_enable(issue_rd_enable),
                .issue_has_exception(issue_has_exception),
                .issue_pop(o_pop[gi]),
                .wb_valid(o_valid[gi]),
                .wb_ready(wb_ready),
                .wb_value(o_value[gi]),
                .wb_rob_id(o_rob[gi]),
                .wb_rd_phy(o_rd[gi]),
                .wb_rd_enable(o_en[gi]),
                .wb_has_exception(o_exc[gi]),
                .fb_enable(o_fb[gi]),
                .fb_phy_id(o_fbphy[gi]),
                .fb_value(o_fbval[gi]),
                .flush(flush)
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference multiply from the RV32M definitions using 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] p;
        sa = (op == 2'd1 || op == 2'd2) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = (op == 2'd1) ? longint'($signed(b)) : longint'({32'd0, b});
        p  = sa * sb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // ---------------- behavioural model of the STAGES=3 unit ----------------
    // An op is a queue entry; it is visible at the output once it is the
    // oldest op and at least 3 cycles have passed since its pop. At most 3
    // ops are held; a new one is admitted if there is room or the output
    // is draining.
    typedef struct {
        logic [31:0] val;
        logic [6:0]  rob;
        logic [5:0]  rd;
        logic        en;
        logic        exc;
        int          pop_cyc;
    } ent_t;

    ent_t mq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic exp_v;
        logic exp_pop;
        logic exp_fb;
        ent_t e;
        if (!rst) begin
            chk("rst_wb_valid", {31'd0, o_valid[1]}, 32'd0);
            chk("rst_issue_pop", {31'd0, o_pop[1]}, 32'd0);
            chk("rst_fb_enable", {31'd0, o_fb[1]}, 32'd0);
            chk("rst_wb_value", o_value[1], 32'd0);
            chk("rst_wb_rob", {25'd0, o_rob[1]}, 32'd0);
            mq.delete();
        end else begin
            exp_v   = (mq.size() > 0) && (cyc >= mq[0].pop_cyc + 3) && !flush;
            exp_pop = issue_valid && !flush && ((mq.size() < 3) || wb_ready);
            chk("m_wb_valid", {31'd0, o_valid[1]}, {31'd0, exp_v});
            chk("m_issue_pop", {31'd0, o_pop[1]}, {31'd0, exp_pop});
            if (exp_v) begin
                exp_fb = mq[0].en && !mq[0].exc && wb_ready;
                chk("m_wb_value", o_value[1], mq[0].val);
                chk("m_wb_rob", {25'd0, o_rob[1]}, {25'd0, mq[0].rob});
                chk("m_wb_rd", {26'd0, o_rd[1]}, {26'd0, mq[0].rd});
                chk("m_wb_en", {31'd0, o_en[1]}, {31'd0, mq[0].en});
                chk("m_wb_exc", {31'd0, o_exc[1]}, {31'd0, mq[0].exc});
                chk("m_fb_enable", {31'd0, o_fb[1]}, {31'd0, exp_fb});
                if (exp_fb) begin
                    chk("m_fb_phy", {26'd0, o_fbphy[1]}, {26'd0, mq[0].rd});
                    chk("m_fb_value", o_fbval[1], mq[0].val);
                end
            end else begin
                chk("m_fb_idle", {31'd0, o_fb[1]}, 32'd0);
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (exp_v && wb_ready) begin
                    $display("wb rob=%0d rd=%0d value=%h exc=%0b", mq[0].rob, mq[0].rd,
                             mq[0].val, mq[0].exc);
                    void'(mq.pop_front());
                end
                if (exp_pop) begin
                    e.val     = issue_has_exception ? 32'd0
                              : ref_mul(issue_op, issue_src1, issue_src2);
                    e.rob     = issue_rob_id;
                    e.rd      = issue_rd_phy;
                    e.en      = issue_rd_enable;
                    e.exc     = issue_has_exception;
                    e.pop_cyc = cyc;
                    mq.push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] rob, input logic [5:0] rd, input logic en,
                          input logic exc);
        issue_valid         = 1'b1;
        issue_op            = op;
        issue_src1          = a;
        issue_src2          = b;
        issue_rob_id        = rob;
        issue_rd_phy        = rd;
        issue_rd_enable     = en;
        issue_has_exception = exc;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
    endtask

    initial begin
        logic [1:0]  s2_op  [4];
        logic [31:0] s2_a   [4];
        logic [31:0] s2_b   [4];
        logic [31:0] s2_exp [4];
        logic [6:0]  got [$];
        logic [6:0]  next_id;
        logic [6:0]  rec_rob;
        logic [31:0] rec_val;
        logic        p;
        int          pops;
        int          lat;

        s2_op  = '{2'd1, 2'd2, 2'd3, 2'd0};
        s2_a   = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3};
        s2_b   = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
        s2_exp = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0000000F};

        // Reset with an op presented: nothing may be popped.
        rst      = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b1;
        set_op(2'd0, 32'd1, 32'd1, 7'd1, 6'd1, 1'b1, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        idle();
        step();
        step();

        // Scenario 1: 7 * 0xFFFFFFFD on all three depths.
        set_op(2'd0, 32'd7, 32'hFFFFFFFD, 7'd10, 6'd5, 1'b1, 1'b0);
        #3;
        chk("s1_pop", {31'd0, o_pop[1]}, 32'd1);
        step();
        idle();
        for (int k = 1; k <= 5; k++) begin
            #3;
            for (int g = 0; g < 3; g++) begin
                lat = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
                chk($sformatf("s1_valid_lat%0d_c%0d", lat, k), {31'd0, o_valid[g]},
                    (k == lat) ? 32'd1 : 32'd0);
                if (k == lat) begin
                    chk($sformatf("s1_value_lat%0d", lat), o_value[g], 32'hFFFFFFEB);
                    chk($sformatf("s1_fb_lat%0d", lat), {31'd0, o_fb[g]}, 32'd1);
                    chk($sformatf("s1_fbphy_lat%0d", lat), {26'd0, o_fbphy[g]}, 32'd5);
                end
            end
            step();
        end

        // Scenario 2: one of each variant back to back.
        for (int i = 0; i < 8; i++) begin
            if (i < 4) set_op(s2_op[i], s2_a[i], s2_b[i], 7'(20 + i), 6'(10 + i), 1'b1, 1'b0);
            else       idle();
            #3;
            if (i >= 3 && i <= 6) begin
                chk($sformatf("s2_valid_%0d", i), {31'd0, o_valid[1]}, 32'd1);
                chk($sformatf("s2_value_%0d", i), o_value[1], s2_exp[i-3]);
                chk($sformatf("s2_rob_%0d", i), {25'd0, o_rob[1]}, 32'(20 + i - 3));
            end else begin
                chk($sformatf("s2_idle_%0d", i), {31'd0, o_valid[1]}, 32'd0);
            end
            step();
        end

        // Scenario 3: backpressure for 6 cycles, then release.
        wb_ready = 1'b0;
        next_id  = 7'd40;
        pops     = 0;
        rec_rob  = '0;
        rec_val  = '0;
        for (int c = 0; c < 6; c++) begin
            set_op(2'd0, 32'(next_id), 32'd3, next_id, 6'd7, 1'b1, 1'b0);
            #3;
            p = o_pop[1];
            if (p) pops++;
            if (c == 3) begin
                rec_rob = o_rob[1];
                rec_val = o_value[1];
                chk("s3_first_rob", {25'd0, rec_rob}, 32'd40);
            end
            if (c > 3) begin
                chk($sformatf("s3_stall_valid_%0d", c), {31'd0, o_valid[1]}, 32'd1);
                chk($sformatf("s3_stall_rob_%0d", c), {25'd0, o_rob[1]}, {25'd0, rec_rob});
                chk($sformatf("s3_stall_value_%0d", c), o_value[1], rec_val);
            end
            step();
            if (p) next_id++;
        end
        chk("s3_pops_stalled", 32'(pops), 32'd3);
        wb_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 5) set_op(2'd0, 32'(next_id), 32'd3, next_id, 6'd7, 1'b1, 1'b0);
            else       idle();
            #3;
            p = o_pop[1] & issue_valid;
            if (c < 5) chk($sformatf("s3_pop_resume_%0d", c), {31'd0, o_pop[1]}, 32'd1);
            if (o_valid[1]) got.push_back(o_rob[1]);
            step();
            if (p) begin
                next_id++;
                pops++;
            end
        end
        chk("s3_result_count", 32'(got.size()), 32'd8);
        foreach (got[k]) chk($sformatf("s3_seq_%0d", k), {25'd0, got[k]}, 32'(40 + k));

        // Scenario 4: flush with the output valid and two ops behind it.
        set_op(2'd3, 32'hFFFFFFFF, 32'd2, 7'd60, 6'd20, 1'b1, 1'b0);
        step();
        set_op(2'd0, 32'd9, 32'd9, 7'd61, 6'd21, 1'b1, 1'b0);
        step();
        set_op(2'd1, 32'hFFFFFFFE, 32'd4, 7'd62, 6'd22, 1'b1, 1'b0);
        step();
        set_op(2'd0, 32'd6, 32'd7, 7'd63, 6'd23, 1'b1, 1'b0);
        flush = 1'b1;
        #3;
        chk("s4_flush_valid", {31'd0, o_valid[1]}, 32'd0);
        chk("s4_flush_fb", {31'd0, o_fb[1]}, 32'd0);
        chk("s4_flush_pop", {31'd0, o_pop[1]}, 32'd0);
        step();
        flush = 1'b0;
        #3;
        chk("s4_repop", {31'd0, o_pop[1]}, 32'd1);
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            #3;
            if (c < 2) chk($sformatf("s4_after_%0d", c), {31'd0, o_valid[1]}, 32'd0);
            else begin
                chk("s4_new_valid", {31'd0, o_valid[1]}, 32'd1);
                chk("s4_new_value", o_value[1], 32'd42);
                chk("s4_new_rob", {25'd0, o_rob[1]}, 32'd63);
            end
            step();
        end

        // Scenario 5: exception passthrough.
        set_op(2'd0, 32'd5, 32'd6, 7'd70, 6'd9, 1'b1, 1'b1);
        step();
        idle();
        step();
        step();
        #3;
        chk("s5_valid", {31'd0, o_valid[1]}, 32'd1);
        chk("s5_exc", {31'd0, o_exc[1]}, 32'd1);
        chk("s5_value", o_value[1], 32'd0);
        chk("s5_fb", {31'd0, o_fb[1]}, 32'd0);
        chk("s5_rob", {25'd0, o_rob[1]}, 32'd70);
        step();

        // Scenario 6: asynchronous reset with a full pipe.
        wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_op(2'd0, 32'(c + 1), 32'd2, 7'(80 + c), 6'(30 + c), 1'b1, 1'b0);
            step();
        end
        set_op(2'd0, 32'd4, 32'd2, 7'd83, 6'd33, 1'b1, 1'b0);
        #1;
        chk("s6_full_valid", {31'd0, o_valid[1]}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("s6_async_valid", {31'd0, o_valid[1]}, 32'd0);
        chk("s6_async_pop", {31'd0, o_pop[1]}, 32'd0);
        chk("s6_async_value", o_value[1], 32'd0);
        step();
        step();
        rst      = 1'b1;
        wb_ready = 1'b1;
        idle();
        for (int c = 0; c < 6; c++) begin
            #3;
            chk($sformatf("s6_quiet_%0d", c), {31'd0, o_valid[1]}, 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_mul_pipe.md
Name: execute_mul_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle multiply execute unit in the out-of-order core.
- Takes micro-ops from the issue mul FIFO and supports all four RV32M multiply variants (mul/mulh/mulhsu/mulhu).
- Has a configurable latency of STAGES cycles, one-op-per-cycle throughput, writeback backpressure and commit flush.
- Results go to the mul writeback port and the physical-register wakeup feedback channel.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 3, pipeline depth (legal 1..4); issue-accept to wb_valid latency in cycles.
- ROB_ID_W, 7, ROB index width.
- PHY_W, 6, physical register index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue mul FIFO has an op at its head.
- issue_op  in  2  0=mul, 1=mulh, 2=mulhsu, 3=mulhu.
- issue_src1  in  XLEN  rs1 value.
- issue_src2  in  XLEN  rs2 value.
- issue_rob_id  in  ROB_ID_W  ROB entry.
- issue_rd_phy  in  PHY_W  destination physical register.
- issue_rd_enable  in  1  op writes rd.
- issue_has_exception  in  1  op carries an upstream exception.
- issue_pop  out  1  head accepted this cycle.
- wb_valid  out  1  result available at the writeback port.
- wb_ready  in  1  writeback port accepts this cycle.
- wb_value  out  XLEN  result.
- wb_rob_id  out  ROB_ID_W  ROB entry of the result.
- wb_rd_phy  out  PHY_W  destination physical register of the result.
- wb_rd_enable  out  1  result writes rd.
- wb_has_exception  out  1  exception passthrough.
- fb_enable  out  1  wakeup feedback valid.
- fb_phy_id  out  PHY_W  wakeup register index.
- fb_value  out  XLEN  wakeup value.
- flush  in  1  commit_feedback flush; kills everything in flight.

Behaviour:
- Reset (rst=0, asynchronous):
  - All stage valid bits clear.
  - issue_pop=0, wb_valid=0, fb_enable=0.
  - All data outputs 0.
  - An op in flight when reset asserts is discarded with no writeback.
- Pipeline structure:
  - STAGES registered slots S0..S(STAGES-1), each holding valid, payload and partial/full product.
  - S(STAGES-1) drives all wb_* outputs.
- Advance rule:
  - adv[last] = !v[last] | wb_ready.
  - adv[i] = !v[i] | adv[i+1].
  - A stage loads from its predecessor when adv[i]; the bubble collapses, so no gaps remain while the output is stalled.
- Accept: issue_pop = issue_valid & adv[0] & !flush. On pop, S0 captures the payload.
- Arithmetic:
  - Operands extended to XLEN+1 bits. src1 is signed for mulh/mulhsu, src2 is signed for mulh only, otherwise zero-extended.
  - Signed (2XLEN+2)-bit product.
  - mul yields product[XLEN-1:0]; the others yield product[2XLEN-1:XLEN].
  - The product may be computed in S0 and delayed, or split across stages; the result must equal the reference formula at wb.
- Exceptions: if has_exception, wb_value=0 and fb_enable stays 0 for that op; ROB id and flag are still written back.
- Latency and throughput:
  - Op popped in cycle N with wb_ready held 1: wb_valid=1 in cycle N+STAGES, combinationally visible after the edge.
  - Back-to-back pops give back-to-back wb_valid.
- Backpressure:
  - While wb_valid & !wb_ready, S(last) holds its contents.
  - Earlier stages fill; at most STAGES ops are in flight.
  - issue_pop=0 once all stages are valid.
- Feedback: fb_enable = wb_valid & wb_ready & wb_rd_enable & !wb_has_exception & !flush. fb_phy_id=wb_rd_phy, fb_value=wb_value.
- Flush:
  - Synchronous; all valid bits clear at the next edge.
  - In the flush cycle issue_pop=0, and wb_valid and fb_enable are forced 0.
  - A pop and a flush in the same cycle cannot occur; pop is masked by flush.
- Simultaneous events:
  - A wb handshake and a new pop in the same cycle are both honoured.
  - With a full pipe, wb_ready=1 and issue_valid=1, one op leaves and one enters in that cycle.
- Width: all arithmetic is XLEN-generic. Results wrap modulo 2^XLEN; there is no overflow flag.

Test Plan:
- STAGES=3, wb_ready=1: pop mul 7 × 0xFFFFFFFD at cycle 10 -> wb_valid at cycle 13, wb_value=0xFFFFFFEB, fb_enable=1 with fb_phy_id=rd_phy.
- Four back-to-back ops, one per op type, with no stall:
  - mulh 0x80000000×0x80000000 -> 0x40000000.
  - mulhsu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
  - mulhu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - mul 3×5 -> 0x0000000F.
  - Results appear on 4 consecutive cycles in issue order.
- wb_ready=0 for 6 cycles with issue_valid constantly 1 -> exactly 3 pops, then issue_pop=0 and wb outputs stable. Releasing wb_ready drains 1 result/cycle while pops resume in the same cycles; no op is lost or duplicated (check by rob_id sequence).
- Flush with 2 ops in flight and wb_valid=1 -> wb_valid=0 and fb_enable=0 in the flush cycle and after; the next op popped afterwards emerges STAGES cycles later with the correct value.
- issue_has_exception=1 with rd_enable=1 -> wb_has_exception=1, wb_value=0, fb_enable=0.
- Assert rst low mid-stream with 3 ops in flight and between clock edges -> wb_valid and issue_pop drop to 0 immediately, nothing is written back after release. Repeat the first scenario with STAGES=1 and STAGES=4: latency is 1 and 4.
